inst_encoder: RTL and testbench

- Streaming RISC-V instruction assembler.
- Accepts decomposed fields: format code, opcode, register indices, funct fields and a signed 32-bit immediate. Scatters the immediate into the format-specific bit positions and emits a registered 32-bit instruction word.
- Feeds the instruction-injection path of the debug/self-test harness, which builds instruction words at run time rather than loading them from memory.
- Includes an immediate range/alignment checker, a 2-entry skid buffer for full-throughput backpressure, and saturating statistics counters.

---
 rtl/inst_encoder_pkg.sv | 34 +++
 rtl/inst_encoder_if.sv | 39 +++
 rtl/inst_encoder_field_pack.sv | 57 +++++
 rtl/inst_encoder.sv | 110 +++++++++++
 tb/tb_inst_encoder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RISC-V instruction assembler: format codes,
// common opcodes, the encoded-word bundle and an immediate range helper.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    InstFormat_R  = 3'd0,
    InstFormat_I  = 3'd1,
    InstFormat_S  = 3'd2,
    InstFormat_SB = 3'd3,
    InstFormat_U  = 3'd4,
    InstFormat_UJ = 3'd5
  } inst_fmt_e;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] JAL    = 7'h6F;

  // One assembled instruction plus its error flag, as held in the pipeline.
  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } enc_word_t;

  // True when the 32-bit value is a sign extension of its low n bits,
  // i.e. it lies in -2^(n-1) .. 2^(n-1)-1.
  function automatic logic imm_fits(input logic [31:0] v, input int unsigned n);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << (n - 1)) - 32'd1);
    return ((v & hi_mask) == 32'd0) || ((v & hi_mask) == hi_mask);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input stream and instruction output stream of the encoder.
//
// Both streams use strict valid/ready: a transfer happens on a rising edge
// where valid && ready; once valid is raised the payload is held stable and
// valid stays high until that transfer; ready may change freely and never
// depends combinationally on valid of the same stream.
interface inst_encoder_if;
  import inst_encoder_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  // Harness side: produces bundles, consumes instructions.
  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/inst_encoder_field_pack.sv
// Combinational packer: scatters the immediate into the format-specific
// bit positions and flags out-of-range or misaligned immediates.
module inst_field_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output enc_word_t   word_o
);

  logic [31:0] inst;
  logic        err;

  // Pack by format; an erroneous bundle yields an all-zero word.
  always_comb begin
    inst = 32'h0;
    err  = 1'b0;
    case (fmt_i)
      InstFormat_R: begin
        inst = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      InstFormat_I: begin
        inst = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        err  = !imm_fits(imm_i, 12);
      end
      InstFormat_S: begin
        inst = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        err  = !imm_fits(imm_i, 12);
      end
      InstFormat_SB: begin
        inst = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                imm_i[4:1], imm_i[11], opcode_i};
        err  = !imm_fits(imm_i, 13) || imm_i[0];
      end
      InstFormat_U: begin
        inst = {imm_i[31:12], rd_i, opcode_i};
        err  = |imm_i[11:0];
      end
      InstFormat_UJ: begin
        inst = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        err  = !imm_fits(imm_i, 21) || imm_i[0];
      end
      default: begin
        err = 1'b1;
      end
    endcase
    if (err) inst = 32'h0;
    word_o = '{err: err, inst: inst};
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction assembler: packer, output register backed by a
// one-word skid entry, and saturating delivery/error counters.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_encoder_if.slave    bus,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  enc_word_t        pack_word;
  logic             out_valid_q, out_valid_d;
  enc_word_t        out_word_q, out_word_d;
  logic             skid_valid_q, skid_valid_d;
  enc_word_t        skid_word_q, skid_word_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             accept;
  logic             drain;

  inst_field_pack u_pack (
    .fmt_i    (bus.in_fmt),
    .opcode_i (bus.in_opcode),
    .rd_i     (bus.in_rd),
    .rs1_i    (bus.in_rs1),
    .rs2_i    (bus.in_rs2),
    .funct3_i (bus.in_funct3),
    .funct7_i (bus.in_funct7),
    .imm_i    (bus.in_imm),
    .word_o   (pack_word)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = out_valid_q && bus.out_ready;

  // Output register refills from the skid entry first, then from the packer;
  // a new word arriving while the output is stalled parks in the skid entry.
  // in_ready is registered from the next skid occupancy so it never sees
  // out_ready combinationally.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;
    if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_word_d   = skid_word_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_word_d  = pack_word;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_word_d  = pack_word;
    end
    in_ready_d = !skid_valid_d;
  end

  // Counters advance on the output handshake, saturate, and clear wins.
  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clear_counts) begin
      enc_cnt_d = '0;
      err_cnt_d = '0;
    end else if (drain) begin
      if (enc_cnt_q != '1) enc_cnt_d = enc_cnt_q + CNT_W'(1);
      if (out_word_q.err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State registers; in_ready rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_word_q  <= '0;
      in_ready_q   <= 1'b0;
      enc_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
      in_ready_q   <= in_ready_d;
      enc_cnt_q    <= enc_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_word_q.inst;
  assign bus.out_err   = out_word_q.err;
  assign enc_count     = enc_cnt_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed spec vectors, backpressure, reset,
// saturation, and a randomized phase checked against a reference model.
module tb_inst_encoder;

  localparam int          CNT_W   = 16;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear_counts = 1'b0;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  inst_encoder_if bus ();

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .clear_counts (clear_counts),
    .enc_count    (enc_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];      // {err, inst} words the encoder still owes
  int          n_vec  = 0;
  int          n_fail = 0;
  int unsigned m_enc  = 0;
  int unsigned m_err  = 0;
  bit          ready_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference assembler written straight from the field layout tables.
  function automatic logic [32:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] imm);
    int signed   s;
    logic [31:0] w;
    bit          bad;
    s   = $signed(imm);
    w   = 32'(op);
    bad = 1'b0;
    case (fmt)
      3'd0: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                  | (32'(rs2) << 20) | (32'(f7) << 25);
      3'd1: begin
        w   = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
        bad = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w   = w | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
        bad = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w   = w | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
        bad = (s < -4096) || (s > 4094) || (imm[0] == 1'b1);
      end
      3'd4: begin
        w   = w | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
        bad = (imm & 32'hFFF) != 32'd0;
      end
      3'd5: begin
        w   = w | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
        bad = (s < -1048576) || (s > 1048574) || (imm[0] == 1'b1);
      end
      default: bad = 1'b1;
    endcase
    if (bad) w = 32'd0;
    return {bad, w};
  endfunction

  // One clock: called on a falling edge with inputs already driven. Checks the
  // outputs against the scoreboard, advances the model, and returns on the
  // next falling edge. acc reports whether the bundle was taken.
  task automatic cycle(output bit acc);
    bit hs;
    bit exp_rdy;
    exp_rdy = (exp_q.size() < 2);
    if (ready_chk) chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_word", 64'({bus.out_err, bus.out_inst}), 64'(exp_q[0]));
    chk("enc_count", 64'(enc_count), 64'(m_enc));
    chk("err_count", 64'(err_count), 64'(m_err));
    acc = bus.in_valid && exp_rdy && ready_chk;
    hs  = (exp_q.size() != 0) && bus.out_ready;
    if (clear_counts) begin
      m_enc = 0;
      m_err = 0;
    end else if (hs) begin
      if (m_enc < CNT_MAX) m_enc++;
      if (exp_q[0][32] && (m_err < CNT_MAX)) m_err++;
    end
    if (hs) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(ref_encode(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1,
                                        bus.in_rs2, bus.in_funct3, bus.in_funct7, bus.in_imm));
    @(posedge clk);
    ready_chk = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    bit a;
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    cycle(a);
    for (int k = 0; k < 20 && !a; k++) cycle(a);
    if (!a) chk("send_timeout", 64'(a), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    bus.in_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle(a);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges [13];
    edges = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd4094, 32'd4095,
              32'd4096, 32'hFFFF_F000, 32'hFFFF_EFFE, 32'h000F_FFFE, 32'h0010_0000,
              32'hFFF0_0000, 32'hFFEF_FFFE};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       return edges[$urandom_range(0, 12)];
      default: return $urandom & 32'hFFFF_F000;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    bit a;
    bit take_new;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_inst", 64'(bus.out_inst), 64'(0));
    chk("rst_out_err", 64'(bus.out_err), 64'(0));
    chk("rst_enc_count", 64'(enc_count), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    rst_n = 1'b1;
    idle(1);

    // Single-format vectors; S and SB go back to back.
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("i_type", 64'(bus.out_inst), 64'(32'h0050_0093));
    chk("i_err", 64'(bus.out_err), 64'(0));
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    chk("s_type", 64'(bus.out_inst), 64'(32'h0020_A423));
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    chk("sb_type", 64'(bus.out_inst), 64'(32'hFE00_0EE3));
    chk("sb_valid", 64'(bus.out_valid), 64'(1));
    chk("sb_in_ready", 64'(bus.in_ready), 64'(1));
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    chk("u_type", 64'(bus.out_inst), 64'(32'h1234_52B7));
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    chk("uj_type", 64'(bus.out_inst), 64'(32'h0010_00EF));

    // Error vectors.
    clear_counts = 1'b1;
    idle(1);
    clear_counts = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("i_range_inst", 64'(bus.out_inst), 64'(0));
    chk("i_range_err", 64'(bus.out_err), 64'(1));
    chk("i_range_cnt0", 64'(err_count), 64'(0));
    idle(1);
    chk("i_range_cnt1", 64'(err_count), 64'(1));
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    chk("sb_even_err", 64'(bus.out_err), 64'(0));
    chk("sb_even_inst", 64'(bus.out_inst), 64'(32'h0000_0363));
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    chk("sb_odd_err", 64'(bus.out_err), 64'(1));
    send(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    chk("bad_fmt_err", 64'(bus.out_err), 64'(1));
    idle(2);

    // Backpressure: two taken, third stalls, all drain in order.
    clear_counts = 1'b1;
    idle(1);
    clear_counts = 1'b0;
    bus.out_ready = 1'b0;
    send(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0);
    send(3'd1, 7'h13, 5'd6, 5'd7, 5'd0, 3'd4, 7'd0, 32'd100);
    chk("bp_ready_low", 64'(bus.in_ready), 64'(0));
    drive(3'd4, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
    cycle(a);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && !a; k++) cycle(a);
    if (!a) chk("bp_third_timeout", 64'(a), 64'(1));
    idle(4);
    chk("bp_count", 64'(enc_count), 64'(3));

    // Asynchronous reset with the skid entry occupied.
    bus.out_ready = 1'b0;
    send(3'd0, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    send(3'd0, 7'h33, 5'd2, 5'd2, 5'd2, 3'd0, 7'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("arst_out_inst", 64'(bus.out_inst), 64'(0));
    chk("arst_enc_count", 64'(enc_count), 64'(0));
    chk("arst_err_count", 64'(err_count), 64'(0));
    exp_q.delete();
    m_enc = 0;
    m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_chk = 1'b0;
    bus.out_ready = 1'b1;
    idle(1);

    // Randomized traffic with payload held while a bundle waits.
    take_new = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (take_new || !bus.in_valid) begin
        drive(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clear_counts  = ($urandom_range(0, 63) == 0);
      cycle(take_new);
    end
    clear_counts = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);

    // Saturation of both counters with a stream of erroneous bundles.
    clear_counts = 1'b1;
    idle(1);
    clear_counts = 1'b0;
    drive(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int k = 0; k < (1 << CNT_W) + 3; k++) cycle(a);
    chk("sat_enc", 64'(enc_count), 64'(CNT_MAX));
    chk("sat_err", 64'(err_count), 64'(CNT_MAX));

    // Clear during a live handshake.
    clear_counts = 1'b1;
    cycle(a);
    clear_counts = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_enc", 64'(enc_count), 64'(0));
    chk("clr_err", 64'(err_count), 64'(0));
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
